// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, centre sampling LSB first,
// stop-bit check with one-cycle VALID / FRAME_ERR strobes.
//
// state       | meaning
// S_IDLE      | line idle, waiting for rx_s low
// S_START     | counting to mid start bit to confirm it is not a glitch
// S_DATA      | sampling the 8 data bits at their centres
// S_STOP      | sampling the stop bit
// S_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int BIT_RATE = 9600,
  parameter int CLK_HZ   = 12_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);
  localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam int CW          = $clog2(CLK_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          // last bit index detected explicitly rather than relying on a wrap to zero
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= RX;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = ferr_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] DATA;
  logic       VALID;
  logic       FRAME_ERR;
  logic       BUSY;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         valid_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_rise_cyc = 0;
  int         busy_fall_cyc = 0;
  logic       busy_prev = 1'b0;
  logic [7:0] last_good = 8'h00;

  always #5 CLK = ~CLK;

  uart_rx #(.BIT_RATE(115200), .CLK_HZ(1_843_200)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .DATA     (DATA),
    .VALID    (VALID),
    .FRAME_ERR(FRAME_ERR),
    .BUSY     (BUSY)
  );

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // monitor: every strobe must match the head of the expectation queue
  initial forever begin
    exp_t e;
    @(negedge CLK);
    if (BUSY && !busy_prev) busy_rise_cyc = cyc;
    if (!BUSY && busy_prev) busy_fall_cyc = cyc;
    busy_prev = BUSY;
    if (VALID && FRAME_ERR) begin
      checks++;
      errors++;
      $display("FAIL strobe_overlap: valid=1 frame_err=1 at cycle %0d, required at most one", cyc);
    end else if (VALID || FRAME_ERR) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got valid=%0b frame_err=%0b data=%02h at cycle %0d, required no strobe",
                 VALID, FRAME_ERR, DATA, cyc);
      end else begin
        e = exp_q.pop_front();
        if (FRAME_ERR !== e.is_err || DATA !== e.data) begin
          errors++;
          $display("FAIL rx_event: got frame_err=%0b data=%02h, required frame_err=%0b data=%02h",
                   FRAME_ERR, DATA, e.is_err, e.data);
        end
      end
      if (VALID) valid_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(CPB);
    end
    RX = stop_bit;
    tick(CPB);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
    last_good = b;
  endtask

  task automatic expect_ferr();
    exp_q.push_back({1'b1, last_good});
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, req, req);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int         t0;
    int         n0;
    int         n;
    logic [7:0] rb;
    logic [7:0] loop_bytes[4];

    RST = 1'b1;
    RX  = 1'b1;
    tick(3);
    check("reset_data", DATA, 0);
    check("reset_valid", VALID, 0);
    check("reset_frame_err", FRAME_ERR, 0);
    check("reset_busy", BUSY, 0);
    RST = 1'b0;
    tick(5);

    // single byte with BUSY timing
    t0 = cyc;
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1);
    tick(20);
    drain("single");
    check_range("busy_rise_delay", busy_rise_cyc - t0, 1, 3);
    check_range("busy_length", busy_fall_cyc - busy_rise_cyc, 150, 154);
    check("single_data_held", DATA, 8'hA5);

    // back-to-back with zero idle
    n0 = valid_cyc.size();
    expect_byte(8'h00);
    send_frame(8'h00, 1'b1);
    expect_byte(8'hFF);
    send_frame(8'hFF, 1'b1);
    tick(20);
    drain("b2b");
    check("b2b_valid_count", valid_cyc.size() - n0, 2);
    if (valid_cyc.size() >= n0 + 2)
      check_range("b2b_spacing", valid_cyc[n0+1] - valid_cyc[n0], 158, 162);

    // glitch rejection
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    n = 0;
    while (BUSY && n < 30) begin
      tick(1);
      n++;
    end
    check_range("glitch_busy_release", n, 0, 12);
    tick(30);
    expect_byte(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(20);
    drain("after_glitch");

    // framing error followed by a long break
    expect_ferr();
    send_frame(8'h55, 1'b0);
    tick(30 * CPB);
    RX = 1'b1;
    tick(40);
    drain("break");
    check("break_data_held", DATA, 8'h3C);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1);
    tick(20);
    drain("after_break");

    // reset during data bit 3
    rb = 8'h77;
    RX = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      RX = rb[i];
      tick(CPB);
    end
    RX = rb[3];
    tick(8);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    RX  = 1'b1;
    check("midrst_data", DATA, 0);
    check("midrst_valid", VALID, 0);
    check("midrst_frame_err", FRAME_ERR, 0);
    check("midrst_busy", BUSY, 0);
    last_good = 8'h00;
    tick(200);
    expect_byte(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(20);
    drain("after_reset");

    // loopback stream: directed then random bytes, back-to-back
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h5A;
    loop_bytes[3] = 8'h96;
    for (int i = 0; i < 4; i++) begin
      expect_byte(loop_bytes[i]);
      send_frame(loop_bytes[i], 1'b1);
    end
    for (int i = 0; i < 64; i++) begin
      rb = 8'($urandom_range(255));
      expect_byte(rb);
      send_frame(rb, 1'b1);
    end
    tick(20);
    drain("loopback");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx transmitter. Uses the same BIT_RATE/CLK_HZ parameterisation so the two pair directly.
- Synchronises the asynchronous RX pin, validates the start bit at mid-bit and samples each data bit at its centre, LSB first.
- Checks the stop bit and presents each byte on DATA with a one-cycle VALID strobe, or a one-cycle FRAME_ERR strobe.

Parameters:
- BIT_RATE, 9600: line bit rate, bits per second.
- CLK_HZ, 12_000_000: CLK frequency in Hz.
- (local) CLK_PER_BIT = CLK_HZ / BIT_RATE (integer division); HALF_BIT = CLK_PER_BIT / 2; counter width = $clog2(CLK_PER_BIT+1).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial line; idle high.
- DATA  output  8  last correctly received byte; held until the next good byte.
- VALID  output  1  one-cycle pulse: DATA was updated this cycle.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset: RST is sampled on posedge CLK and takes priority over everything. It sets state=IDLE, both sync FFs=1, counters=0, shift register=0, DATA=0, VALID=0, FRAME_ERR=0, BUSY=0. RST asserted mid-frame aborts the frame; no VALID or FRAME_ERR is produced for that frame.
- Input sync: RX passes through 2 FFs to give rx_s. No logic uses raw RX.
- Timing reference: c = first cycle in IDLE where rx_s==0.
- IDLE: on rx_s==0, go to START and clear the clock counter.
- START: sample rx_s at edge c+HALF_BIT.
  - If rx_s==1: glitch; return to IDLE with no strobes.
  - If rx_s==0: go to DATA, clear the clock counter and the bit index.
- DATA: data bit k (k=0..7) is sampled at edge c+HALF_BIT+(k+1)*CLK_PER_BIT. Each sample shifts into the shift register MSB, shifting right, so bit 0 ends up in DATA[0]. After bit 7, go to STOP.
- STOP: sample at edge c+HALF_BIT+9*CLK_PER_BIT.
  - If rx_s==1: DATA<=shift register, VALID=1 for exactly one cycle, go to IDLE.
  - If rx_s==0: FRAME_ERR=1 for one cycle, DATA unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held break therefore yields exactly one FRAME_ERR and no spurious frames.
- Strobes: VALID and FRAME_ERR are registered and never high together. They are 0 in every cycle other than the one following the stop sample.
- Back-to-back frames: IDLE is re-entered on the cycle after the stop sample, so a start edge arriving at the nominal end of the stop bit is accepted. Minimum supported gap between frames: zero idle bits.
- Sample-edge accuracy: ±1 CLK of the stated edges is acceptable. The end-to-end RX→VALID latency is fixed for a given parameter set (no jitter between frames).
- Counter wrap: the clock counter is cleared at each sample point and never free-runs past CLK_PER_BIT. The bit index is 3 bits wide, and the 8-bit case is detected explicitly; no overflow wrap is relied on.

Test Plan:
- Sim params: BIT_RATE=115200, CLK_HZ=1_843_200 (CLK_PER_BIT=16, HALF_BIT=8).
- Single byte: drive 0xA5 as 8N1 (start, 1,0,1,0,0,1,0,1, stop) → exactly one VALID pulse, DATA=0xA5, FRAME_ERR never high. BUSY rises 1–3 cycles after RX falls and drops about 9.5 bit times later.
- Back-to-back: 0x00 then 0xFF with zero idle between frames → two VALID pulses 160±2 cycles apart, DATA=0x00 then 0xFF.
- Glitch rejection: RX low for 4 cycles then high → no VALID, no FRAME_ERR, BUSY returns low within 12 cycles. A following 0x3C frame is received correctly.
- Framing/break: 0x55 with stop bit low, then RX held low 30 bit times, then released → one FRAME_ERR pulse, no VALID, DATA keeps its previous value. A subsequent 0x81 frame is received correctly.
- Reset mid-frame: assert RST for 1 cycle during data bit 3 → all outputs 0 next cycle, no strobe for the aborted frame. The next full frame 0xC3 is received correctly.
- Loopback with uart_tx (same params): send 0x00, 0xFF, 0x5A, 0x96 and 64 random bytes → every byte matches, no FRAME_ERR.
